data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder on the far side of the CPU core's MEM-stage data port.
- Consumes the core's mem_ctrl_input, address and w_data, and returns read_data in the same cycle so the MEM stage timing is unchanged.
- Writes are posted through a one-entry write buffer; reads forward from that buffer.
- Illegal, misaligned and out-of-range accesses are flagged on a sticky error output.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two, at least 2.
- AW, 8, word-index width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_ctrl_input  input  2  access command: 00 idle, 01 read, 10 write, 11 illegal.
- address  input  32  byte address from the core.
- w_data  input  32  store data; sampled only on a write command.
- read_data  output  32  load data; combinational.
- err  output  1  sticky access-error flag.

Behaviour:
- Word index: idx = address[AW+1:2].
- Valid access: address[1:0]==0 and address < DEPTH*4.
- Any access that is not valid is a bad access:
  - No array or buffer update.
  - read_data = 0.
  - err set on the next rising edge.
- Command 11: treated as idle and sets err on the next edge.
- Write buffer state: buf_vld (1), buf_idx (AW), buf_dat (32).
- Every rising edge with buf_vld=1: mem[buf_idx] <= buf_dat (drain).
- Valid write on the same edge:
  - buf_idx <= idx, buf_dat <= w_data, buf_vld <= 1.
  - Otherwise buf_vld <= 0.
  - Drain and refill occur on the same edge. Back-to-back writes never stall or drop, including to the same index; the later write wins.
- Read, combinational:
  - If buf_vld and buf_idx==idx: read_data = buf_dat (forward).
  - Else: read_data = mem[idx].
  - Non-read commands drive read_data = 0.
- Write-then-read latency:
  - Data written at edge N is visible to a read in cycle N+1 via forwarding.
  - It is visible from the array from cycle N+2 onward.
- err is set by any bad access or command 11. It stays set until reset; no software clear.
- Reset (asynchronous, active-low), effective immediately and mid-operation:
  - buf_vld=0 and err=0.
  - All mem words = 0.
  - read_data = 0 while reset_n=0.
  - A posted write not yet drained when reset asserts is discarded.
- After reset deasserts, the first edge behaves normally. No warm-up cycles.
- No wrap-around: addresses at or above DEPTH*4 are errors and are never aliased onto low words.

Optional Feature:
- Macro: DATA_MEM_ACCESS_CNT_EN.
- Defined:
  - Adds output ports rd_cnt (16) and wr_cnt (16).
  - Each counts valid reads and valid writes on each rising edge.
  - Both saturate at 16'hFFFF and reset to 0.
  - Bad accesses and command 11 are not counted.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then read 0x00000010 -> read_data=0 and err=0.
2. Write 0x00000010 / 0xDEADBEEF, then read 0x10 next cycle -> 0xDEADBEEF via forward. Idle one cycle, then read 0x10 -> 0xDEADBEEF from the array.
3. Write addr 0x20 = 0x1, then addr 0x20 = 0x2 back-to-back, then read 0x20 -> 0x2. Read 0x24 -> 0.
4. Read 0x00000402 (misaligned) -> read_data=0, err=1 next edge. Then write 0x400 (out of range for DEPTH=256) -> word 0 unchanged, err stays 1.
5. Command 11 -> err=1. Assert reset_n=0 asynchronously mid-cycle right after a write to 0x8 -> err=0 and buf_vld=0 immediately. After release, read 0x8 -> 0.
6. With DATA_MEM_ACCESS_CNT_EN: 3 valid writes, 2 valid reads, 1 misaligned read -> wr_cnt=3, rd_cnt=2.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// MEM-stage data port between the CPU core (master) and the data-memory responder (slave).
// DATA_MEM_ACCESS_CNT_EN adds the rd_cnt/wr_cnt access counters.
interface data_mem_responder_if;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic [1:0]    mem_ctrl_input;
    logic [DW-1:0] address;
    logic [DW-1:0] w_data;
    logic [DW-1:0] read_data;
    logic          err;
`ifdef DATA_MEM_ACCESS_CNT_EN
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;
`endif

`ifdef DATA_MEM_ACCESS_CNT_EN
    modport master (
        output mem_ctrl_input, address, w_data,
        input  read_data, err, rd_cnt, wr_cnt
    );
    modport slave (
        input  mem_ctrl_input, address, w_data,
        output read_data, err, rd_cnt, wr_cnt
    );
`else
    modport master (
        output mem_ctrl_input, address, w_data,
        input  read_data, err
    );
    modport slave (
        input  mem_ctrl_input, address, w_data,
        output read_data, err
    );
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: same-cycle reads, writes posted through a one-entry forwarding buffer,
// sticky error on bad accesses. DATA_MEM_ACCESS_CNT_EN adds saturating read/write counters.
module data_mem_responder #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned DW = 32;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;

    logic [DW-1:0] r_mem [DEPTH];
    logic          r_buf_vld;
    logic [AW-1:0] r_buf_idx;
    logic [DW-1:0] r_buf_dat;
    logic          r_err;

    logic [AW-1:0] w_idx;
    logic          w_valid;
    logic          w_is_rd;
    logic          w_is_wr;
    logic          w_rd_ok;
    logic          w_wr_ok;
    logic          w_bad;
    logic [DW-1:0] w_rd_data;

    // Address decode: aligned and below DEPTH*4, upper bits never alias onto low words.
    assign w_idx   = bus.address[AW+1:2];
    assign w_valid = (bus.address[1:0] == 2'b00) && ((bus.address >> (AW + 2)) == '0);
    assign w_is_rd = (bus.mem_ctrl_input == CMD_RD);
    assign w_is_wr = (bus.mem_ctrl_input == CMD_WR);
    assign w_rd_ok = w_is_rd && w_valid;
    assign w_wr_ok = w_is_wr && w_valid;
    assign w_bad   = (bus.mem_ctrl_input == CMD_ILL) || ((w_is_rd || w_is_wr) && !w_valid);

    // Load path: forward the pending posted write, else read the array.
    always_comb begin
        w_rd_data = '0;
        if (reset_n && w_rd_ok) begin
            if (r_buf_vld && (r_buf_idx == w_idx)) begin
                w_rd_data = r_buf_dat;
            end else begin
                w_rd_data = r_mem[w_idx];
            end
        end
    end

    // Array: drains the write buffer every edge it holds data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_buf_vld) begin
            r_mem[r_buf_idx] <= r_buf_dat;
        end
    end

    // Write buffer refills on the same edge it drains, so back-to-back writes never stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_vld <= 1'b0;
            r_buf_idx <= '0;
            r_buf_dat <= '0;
        end else begin
            r_buf_vld <= w_wr_ok;
            if (w_wr_ok) begin
                r_buf_idx <= w_idx;
                r_buf_dat <= bus.w_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign bus.read_data = w_rd_data;
    assign bus.err       = r_err;

`ifdef DATA_MEM_ACCESS_CNT_EN
    localparam int unsigned CW = 16;
    logic [CW-1:0] r_rd_cnt;
    logic [CW-1:0] r_wr_cnt;

    // Saturating counts of valid accesses only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_ok && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + CW'(1);
            end
            if (w_wr_ok && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + CW'(1);
            end
        end
    end

    assign bus.rd_cnt = r_rd_cnt;
    assign bus.wr_cnt = r_wr_cnt;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic against a
// word-array model in which a write is visible to any read after its edge.
module tb_data_mem_responder;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    data_mem_responder_if bus ();

    data_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [DEPTH];
    logic        ref_err;
    int          ref_rd;
    int          ref_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'(DEPTH * 4));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
        ref_err = 1'b0;
        ref_rd  = 0;
        ref_wr  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        bus.mem_ctrl_input = 2'b00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One bus cycle: drive, check the same-cycle load, clock, then check sticky state.
    task automatic step(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] d,
                        input string tag);
        logic [31:0] exp_rd;
        logic        ok;
        logic [31:0] ai;
        @(negedge clk);
        bus.mem_ctrl_input = cmd;
        bus.address        = a;
        bus.w_data         = d;
        #1;
        ok     = addr_ok(a);
        ai     = a >> 2;
        exp_rd = (cmd == 2'b01 && ok) ? ref_mem[ai[AW-1:0]] : 32'h0;
        check({tag, "/rd"}, bus.read_data, exp_rd);
        @(posedge clk);
        if (cmd == 2'b10 && ok) begin
            ref_mem[ai[AW-1:0]] = d;
            if (ref_wr < 65535) ref_wr++;
        end
        if (cmd == 2'b01 && ok && ref_rd < 65535) ref_rd++;
        if (cmd == 2'b11 || ((cmd == 2'b01 || cmd == 2'b10) && !ok)) ref_err = 1'b1;
        #1;
        check({tag, "/err"}, {31'b0, bus.err}, {31'b0, ref_err});
`ifdef DATA_MEM_ACCESS_CNT_EN
        check({tag, "/rdcnt"}, {16'b0, bus.rd_cnt}, 32'(ref_rd));
        check({tag, "/wrcnt"}, {16'b0, bus.wr_cnt}, 32'(ref_wr));
`endif
    endtask

    task automatic random_phase(input int n, input int bad_pct, input string tag);
        logic [1:0]  cmd;
        logic [31:0] a;
        int          r;
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)      cmd = 2'b10;
            else if (r < 85) cmd = 2'b01;
            else             cmd = 2'b00;
            a = 32'($urandom_range(0, 7)) << 2;
            if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            if (int'($urandom_range(0, 99)) < bad_pct) begin
                case ($urandom_range(0, 2))
                    0:       a = a | 32'($urandom_range(1, 3));
                    1:       a = a | (32'h1 << $urandom_range(AW + 2, 31));
                    default: cmd = 2'b11;
                endcase
            end
            step(cmd, a, $urandom, tag);
        end
    endtask

    initial begin
        bus.mem_ctrl_input = 2'b00;
        bus.address        = 32'h0;
        bus.w_data         = 32'h0;
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        check("reset/err", {31'b0, bus.err}, 32'h0);
        check("reset/rd", bus.read_data, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 1: read after reset
        step(2'b01, 32'h10, 32'h0, "t1_read");
        // 2: forward next cycle, then array after an idle
        step(2'b10, 32'h10, 32'hDEADBEEF, "t2_wr");
        step(2'b01, 32'h10, 32'h0, "t2_fwd");
        step(2'b00, 32'h0, 32'h0, "t2_idle");
        step(2'b01, 32'h10, 32'h0, "t2_arr");
        // 3: back-to-back same-index writes, later wins
        step(2'b10, 32'h20, 32'h1, "t3_wr1");
        step(2'b10, 32'h20, 32'h2, "t3_wr2");
        step(2'b01, 32'h20, 32'h0, "t3_rd");
        step(2'b01, 32'h24, 32'h0, "t3_rd24");
        // 4: misaligned read, out-of-range write does not alias to word 0
        step(2'b01, 32'h402, 32'h0, "t4_mis");
        step(2'b10, 32'h400, 32'hCAFEF00D, "t4_oor");
        step(2'b01, 32'h0, 32'h0, "t4_w0");
        // 5: illegal command, then async reset right after a write
        do_reset();
        step(2'b11, 32'h0, 32'h0, "t5_ill");
        step(2'b10, 32'h8, 32'h12345678, "t5_wr");
        #2 reset_n = 1'b0;
        #1;
        check("t5_async/err", {31'b0, bus.err}, 32'h0);
        check("t5_async/bufvld", {31'b0, dut.r_buf_vld}, 32'h0);
        bus.mem_ctrl_input = 2'b01;
        bus.address        = 32'h8;
        #1;
        check("t5_async/rd", bus.read_data, 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(2'b01, 32'h8, 32'h0, "t5_rd8");
        step(2'b00, 32'h0, 32'h0, "t5_idle");
        step(2'b01, 32'h8, 32'h0, "t5_rd8b");
        // 6: counters (checked inside each step when enabled)
        do_reset();
        step(2'b10, 32'h0, 32'hA, "t6_w0");
        step(2'b10, 32'h4, 32'hB, "t6_w1");
        step(2'b10, 32'hFC, 32'hC, "t6_w2");
        step(2'b01, 32'h4, 32'h0, "t6_r0");
        step(2'b01, 32'h0, 32'h0, "t6_r1");
        step(2'b01, 32'h5, 32'h0, "t6_rmis");
`ifdef DATA_MEM_ACCESS_CNT_EN
        check("t6/wr_cnt", {16'b0, bus.wr_cnt}, 32'd3);
        check("t6/rd_cnt", {16'b0, bus.rd_cnt}, 32'd2);
`endif
        // Randomized traffic: clean phase keeps err low, then mixed with bad accesses
        do_reset();
        random_phase(400, 0, "rnd_clean");
        random_phase(300, 10, "rnd_mixed");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
